// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter family.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter of gray_counter_n
//   bin2gray(width, bin)  : reflected Gray encoding of a binary value, masked to width
//   gray2bin(width, gray) : inverse of bin2gray, masked to width
// The functions take up to 16-bit operands and are meant for behavioural checks.
package gray_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic logic [15:0] width_mask(input int width);
        return 16'hFFFF >> (16 - width);
    endfunction

    function automatic logic [15:0] bin2gray(input int width, input logic [15:0] bin);
        return (bin ^ (bin >> 1)) & width_mask(width);
    endfunction

    // Each binary bit is the parity of the Gray bits at and above it.
    function automatic logic [15:0] gray2bin(input int width, input logic [15:0] gray);
        logic [15:0] g;
        logic [15:0] b;
        g = gray & width_mask(width);
        b = '0;
        for (int i = 0; i < 16; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary converter.
//   gray : WIDTH-bit reflected Gray code in
//   bin  : WIDTH-bit binary equivalent out
module gray2bin_n
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Prefix XOR from the MSB down: bin[i] is the parity of gray[WIDTH-1:i].
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter.
//   Clk, Reset_n      : clock and synchronous active-low reset
//   En, Up            : count enable and direction (1 = up)
//   Load, Load_Value  : parallel load of a Gray-coded value (beats En)
//   Clear_Flags       : clears the sticky flags; a same-cycle set wins
//   Output, Binary    : current count in Gray and binary form
//   Overflow          : sticky, up-step attempted from the maximum
//   Underflow         : sticky, down-step attempted from zero
//   Wrap              : one-cycle pulse after a wrapping step
// SATURATE selects MODE_WRAP (roll over) or MODE_SAT (hold at the end value).
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int SATURATE = MODE_WRAP,
    parameter int INIT     = 0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_Value,
    input  logic             Clear_Flags,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] INIT_BIN = WIDTH'(INIT);
    localparam bit               SAT_EN   = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_bin;

    gray2bin_n #(.WIDTH(WIDTH)) u_load_conv (
        .gray (Load_Value),
        .bin  (load_bin)
    );

    always_comb begin
        cnt_d  = cnt_q;
        // Clear first so that a flag set later in this block overrides it.
        ovf_d  = ovf_q & ~Clear_Flags;
        unf_d  = unf_q & ~Clear_Flags;
        wrap_d = 1'b0;
        if (Load) begin
            cnt_d = load_bin;
        end else if (En) begin
            if (Up) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                    if (!SAT_EN) begin
                        cnt_d  = CNT_ZERO;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                if (cnt_q == CNT_ZERO) begin
                    unf_d = 1'b1;
                    if (!SAT_EN) begin
                        cnt_d  = CNT_MAX;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q  <= INIT_BIN;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            wrap_q <= wrap_d;
        end
    end

    assign Binary    = cnt_q;
    assign Output    = cnt_q ^ (cnt_q >> 1);
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Three counter instances share one stimulus stream:
//   a: WIDTH=3 wrap INIT=0, b: WIDTH=4 saturate INIT=0, c: WIDTH=3 wrap INIT=5.
// Each stimulus edge updates an arithmetic reference model and queues the
// expected state; a monitor pops and compares after every rising edge.
module tb_gray_counter_n;

    typedef struct packed {
        logic [15:0] bin;
        logic [15:0] gray;
        logic        ovf;
        logic        unf;
        logic        wrap;
    } exp_t;

    logic       clk;
    logic       rst_n, en, up, ld, clr;
    logic [3:0] lv;

    logic [2:0] gray_a, bin_a, gray_c, bin_c;
    logic [3:0] gray_b, bin_b;
    logic       ovf_a, unf_a, wrap_a;
    logic       ovf_b, unf_b, wrap_b;
    logic       ovf_c, unf_c, wrap_c;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int m_w[3]    = '{3, 4, 3};
    int m_sat[3]  = '{0, 1, 0};
    int m_init[3] = '{0, 0, 5};
    int m_cnt[3];
    bit m_ovf[3];
    bit m_unf[3];
    bit m_wrap[3];

    gray_counter_n #(.WIDTH(3), .SATURATE(0), .INIT(0)) u_a (
        .Clk(clk), .Reset_n(rst_n), .En(en), .Up(up), .Load(ld),
        .Load_Value(lv[2:0]), .Clear_Flags(clr), .Output(gray_a),
        .Binary(bin_a), .Overflow(ovf_a), .Underflow(unf_a), .Wrap(wrap_a));

    gray_counter_n #(.WIDTH(4), .SATURATE(1), .INIT(0)) u_b (
        .Clk(clk), .Reset_n(rst_n), .En(en), .Up(up), .Load(ld),
        .Load_Value(lv), .Clear_Flags(clr), .Output(gray_b),
        .Binary(bin_b), .Overflow(ovf_b), .Underflow(unf_b), .Wrap(wrap_b));

    gray_counter_n #(.WIDTH(3), .SATURATE(0), .INIT(5)) u_c (
        .Clk(clk), .Reset_n(rst_n), .En(en), .Up(up), .Load(ld),
        .Load_Value(lv[2:0]), .Clear_Flags(clr), .Output(gray_c),
        .Binary(bin_c), .Overflow(ovf_c), .Underflow(unf_c), .Wrap(wrap_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: the count is a plain integer on 0..2^W-1.
    function automatic void model_step(input int k, input bit r, input bit e, input bit u,
                                       input bit l, input logic [3:0] v, input bit c);
        int   maxv;
        int   lvm;
        exp_t x;
        maxv = (1 << m_w[k]) - 1;
        if (!r) begin
            m_cnt[k] = m_init[k];
            m_ovf[k] = 0; m_unf[k] = 0; m_wrap[k] = 0;
        end else begin
            m_wrap[k] = 0;
            if (c) begin
                m_ovf[k] = 0; m_unf[k] = 0;
            end
            if (l) begin
                lvm = int'(v) & maxv;
                // Decode by searching for the value whose Gray code matches.
                for (int n = 0; n <= maxv; n++) begin
                    if ((n ^ (n >> 1)) == lvm) m_cnt[k] = n;
                end
            end else if (e) begin
                if (u) begin
                    if (m_cnt[k] == maxv) begin
                        m_ovf[k] = 1;
                        if (m_sat[k] == 0) begin
                            m_cnt[k] = 0; m_wrap[k] = 1;
                        end
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end else begin
                    if (m_cnt[k] == 0) begin
                        m_unf[k] = 1;
                        if (m_sat[k] == 0) begin
                            m_cnt[k] = maxv; m_wrap[k] = 1;
                        end
                    end else begin
                        m_cnt[k] = m_cnt[k] - 1;
                    end
                end
            end
        end
        x.bin  = 16'(m_cnt[k]);
        x.gray = 16'(m_cnt[k] ^ (m_cnt[k] >> 1));
        x.ovf  = m_ovf[k];
        x.unf  = m_unf[k];
        x.wrap = m_wrap[k];
        case (k)
            0:       q_a.push_back(x);
            1:       q_b.push_back(x);
            default: q_c.push_back(x);
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cmp_inst(input string name, input exp_t e, input logic [15:0] b,
                            input logic [15:0] g, input logic o, input logic u, input logic w);
        chk({name, " bin"},  b, e.bin);
        chk({name, " gray"}, g, e.gray);
        chk({name, " ovf"},  16'(o), 16'(e.ovf));
        chk({name, " unf"},  16'(u), 16'(e.unf));
        chk({name, " wrap"}, 16'(w), 16'(e.wrap));
    endtask

    // Monitor: every rising edge presents a new state for each instance.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                cmp_inst("sb_a", e, 16'(bin_a), 16'(gray_a), ovf_a, unf_a, wrap_a);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                cmp_inst("sb_b", e, 16'(bin_b), 16'(gray_b), ovf_b, unf_b, wrap_b);
            end
            if (q_c.size() > 0) begin
                e = q_c.pop_front();
                cmp_inst("sb_c", e, 16'(bin_c), 16'(gray_c), ovf_c, unf_c, wrap_c);
            end
        end
    end

    task automatic step(input bit r, input bit e, input bit u, input bit l,
                        input logic [3:0] v, input bit c);
        @(negedge clk);
        rst_n = r; en = e; up = u; ld = l; lv = v; clr = c;
        for (int k = 0; k < 3; k++) model_step(k, r, e, u, l, v, c);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    logic [2:0] up_tbl[8];

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b0; ld = 1'b0; lv = 4'd0; clr = 1'b0;
        up_tbl = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

        // Reset state
        step(0, 0, 0, 0, 4'd0, 0);
        step(0, 1, 1, 1, 4'd3, 1);
        settle();
        chk("reset gray_a", 16'(gray_a), 16'h0);
        chk("reset bin_c", 16'(bin_c), 16'd5);
        chk("reset ovf_a", 16'(ovf_a), 16'd0);

        // Up-count with wrap
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, 0, 4'd0, 0);
            settle();
            chk("upseq gray_a", 16'(gray_a), 16'(up_tbl[i]));
            chk("upseq wrap_a", 16'(wrap_a), (i == 7) ? 16'd1 : 16'd0);
            chk("upseq ovf_a", 16'(ovf_a), (i == 7) ? 16'd1 : 16'd0);
        end
        step(1, 0, 0, 0, 4'd0, 0);
        settle();
        chk("wrap pulse end", 16'(wrap_a), 16'd0);

        // Down-count underflow
        step(0, 0, 0, 0, 4'd0, 0);
        step(1, 1, 0, 0, 4'd0, 0);
        settle();
        chk("under gray_a", 16'(gray_a), 16'b100);
        chk("under bin_a", 16'(bin_a), 16'd7);
        chk("under unf_a", 16'(unf_a), 16'd1);
        chk("under wrap_a", 16'(wrap_a), 16'd1);
        step(1, 1, 0, 0, 4'd0, 0);
        settle();
        chk("under next gray_a", 16'(gray_a), 16'b101);

        // Saturate mode on instance b
        step(1, 0, 0, 1, 4'b1000, 0);
        settle();
        chk("sat load bin_b", 16'(bin_b), 16'd15);
        step(1, 1, 1, 0, 4'd0, 0);
        settle();
        chk("sat hold gray_b", 16'(gray_b), 16'b1000);
        chk("sat ovf_b", 16'(ovf_b), 16'd1);
        chk("sat wrap_b", 16'(wrap_b), 16'd0);
        step(1, 1, 0, 0, 4'd0, 0);
        settle();
        chk("sat down bin_b", 16'(bin_b), 16'd14);
        chk("sat down gray_b", 16'(gray_b), 16'b1001);

        // Load priority over enable
        step(1, 1, 1, 1, 4'b0110, 0);
        settle();
        chk("ldpri bin_a", 16'(bin_a), 16'd4);
        chk("ldpri gray_a", 16'(gray_a), 16'b110);
        chk("ldpri ovf_a", 16'(ovf_a), 16'd0);
        chk("ldpri unf_a", 16'(unf_a), 16'd1);
        step(1, 1, 1, 0, 4'd0, 0);
        settle();
        chk("ldpri next gray_a", 16'(gray_a), 16'b111);

        // Clear versus set collision
        step(1, 0, 0, 1, 4'b0100, 0);
        step(1, 1, 1, 0, 4'd0, 0);
        step(1, 0, 0, 1, 4'b0100, 0);
        step(1, 1, 1, 0, 4'd0, 1);
        settle();
        chk("collide ovf_a", 16'(ovf_a), 16'd1);
        chk("collide unf_a", 16'(unf_a), 16'd0);
        step(1, 0, 0, 0, 4'd0, 1);
        settle();
        chk("clear ovf_a", 16'(ovf_a), 16'd0);

        // Reset mid-operation on instance c
        step(0, 0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 4'd0, 0);
        settle();
        chk("mid bin_c", 16'(bin_c), 16'd2);
        chk("mid ovf_c", 16'(ovf_c), 16'd1);
        step(0, 1, 1, 0, 4'd0, 0);
        settle();
        chk("rst bin_c", 16'(bin_c), 16'd5);
        chk("rst gray_c", 16'(gray_c), 16'b111);
        chk("rst ovf_c", 16'(ovf_c), 16'd0);
        chk("rst unf_c", 16'(unf_c), 16'd0);
        chk("rst wrap_c", 16'(wrap_c), 16'd0);
        step(1, 1, 1, 0, 4'd0, 0);
        settle();
        chk("resume bin_c", 16'(bin_c), 16'd6);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0));
        end

        step(1, 0, 0, 0, 4'd0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("drain q_a", 16'(q_a.size()), 16'd0);
        chk("drain q_b", 16'(q_b.size()), 16'd0);
        chk("drain q_c", 16'(q_c.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
